// File: rtl/stack_cpu.sv
// Stack-machine core: 16-bit instruction words from ROM, data stack in RAM behind a cached TOS register.
// Optional MUL opcode (0x2004) is built only when STACK_CPU_MUL_EN is defined.
module stack_cpu #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned STACK_DEPTH = 64,
    parameter int unsigned STACK_BASE  = 0,
    parameter int unsigned MEM_LAT     = 2
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_q,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              halted,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] sp_out,
    output logic [DATA_W-1:0] tos_out
);
    localparam int unsigned       WAIT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LAT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO       = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] DEPTH     = ADDR_W'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(STACK_BASE);

    localparam logic [15:0] OP_NOP  = 16'h0000;
    localparam logic [15:0] OP_IMM  = 16'h0002;
    localparam logic [15:0] OP_JMP  = 16'h1000;
    localparam logic [15:0] OP_JZ   = 16'h1001;
    localparam logic [15:0] OP_ADD  = 16'h2000;
    localparam logic [15:0] OP_SUB  = 16'h2001;
    localparam logic [15:0] OP_AND  = 16'h2002;
    localparam logic [15:0] OP_OR   = 16'h2003;
    localparam logic [15:0] OP_MUL  = 16'h2004;
    localparam logic [15:0] OP_DUP  = 16'h3000;
    localparam logic [15:0] OP_DROP = 16'h3001;
    localparam logic [15:0] OP_HALT = 16'hFFFF;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_OPER_WAIT, S_RD_WAIT, S_EXEC, S_HALT, S_ERROR
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] sp;
    logic [DATA_W-1:0] tos;
    logic [15:0]       op;

    logic              legal;
    logic              grows;
    logic [ADDR_W-1:0] need;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] alu;
    logic              lat_done;

    assign rom_addr = pc;
    assign pc_out   = pc;
    assign sp_out   = sp;
    assign tos_out  = tos;
    assign imm_ext  = DATA_W'($signed(rom_q));
    assign lat_done = (wait_cnt == WAIT_LAST);

    // Opcode legality, minimum stack depth and stack growth of the word on rom_q
    always_comb begin
        legal = 1'b1;
        grows = 1'b0;
        need  = '0;
        case (rom_q)
            OP_NOP, OP_JMP, OP_HALT: need = '0;
            OP_IMM:                  grows = 1'b1;
            OP_JZ, OP_DROP:          need = ONE;
            OP_DUP: begin
                need  = ONE;
                grows = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: need = TWO;
`ifdef STACK_CPU_MUL_EN
            OP_MUL: need = TWO;
`endif
            default: legal = 1'b0;
        endcase
    end

    // Binary ops take NOS from the RAM read and TOS from the cache
    always_comb begin
        alu = '0;
        case (op)
            OP_ADD: alu = ram_q + tos;
            OP_SUB: alu = ram_q - tos;
            OP_AND: alu = ram_q & tos;
            OP_OR:  alu = ram_q | tos;
`ifdef STACK_CPU_MUL_EN
            OP_MUL: alu = ram_q * tos;
`endif
            default: alu = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            pc        <= '0;
            sp        <= '0;
            tos       <= '0;
            op        <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wren  <= 1'b0;
            halted    <= 1'b0;
            error     <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            ram_wren <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (lat_done) begin
                        wait_cnt <= '0;
                        state    <= S_DECODE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                    end
                end
                S_DECODE: begin
                    op <= rom_q;
                    if (!legal) begin
                        error    <= 1'b1;
                        err_code <= 2'd3;
                        state    <= S_ERROR;
                    end else if (sp < need) begin
                        error    <= 1'b1;
                        err_code <= 2'd2;
                        state    <= S_ERROR;
                    end else if (grows && sp >= DEPTH) begin
                        error    <= 1'b1;
                        err_code <= 2'd1;
                        state    <= S_ERROR;
                    end else begin
                        case (rom_q)
                            OP_NOP: begin
                                pc    <= pc + ONE;
                                state <= S_FETCH;
                            end
                            OP_HALT: begin
                                halted <= 1'b1;
                                state  <= S_HALT;
                            end
                            OP_IMM, OP_JMP, OP_JZ: begin
                                pc    <= pc + ONE;
                                state <= S_OPER_WAIT;
                            end
                            OP_DUP: begin
                                ram_addr  <= BASE + sp - ONE;
                                ram_wdata <= tos;
                                ram_wren  <= 1'b1;
                                state     <= S_EXEC;
                            end
                            OP_DROP: begin
                                ram_addr <= BASE + sp - TWO;
                                state    <= (sp >= TWO) ? S_RD_WAIT : S_EXEC;
                            end
                            default: begin
                                ram_addr <= BASE + sp - TWO;
                                state    <= S_RD_WAIT;
                            end
                        endcase
                    end
                end
                S_OPER_WAIT: begin
                    if (lat_done) begin
                        wait_cnt <= '0;
                        // The operand address stays on rom_addr, so rom_q is still valid in EXEC
                        if (op == OP_IMM && sp != '0) begin
                            ram_addr  <= BASE + sp - ONE;
                            ram_wdata <= tos;
                            ram_wren  <= 1'b1;
                        end
                        if (op == OP_JZ && sp >= TWO) begin
                            ram_addr <= BASE + sp - TWO;
                            state    <= S_RD_WAIT;
                        end else begin
                            state <= S_EXEC;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                    end
                end
                S_RD_WAIT: begin
                    if (lat_done) begin
                        wait_cnt <= '0;
                        state    <= S_EXEC;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                    end
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    case (op)
                        OP_IMM: begin
                            tos <= imm_ext;
                            sp  <= sp + ONE;
                            pc  <= pc + ONE;
                        end
                        OP_JMP: pc <= ADDR_W'(rom_q);
                        OP_JZ: begin
                            pc  <= (tos == '0) ? ADDR_W'(rom_q) : pc + ONE;
                            sp  <= sp - ONE;
                            tos <= (sp >= TWO) ? ram_q : '0;
                        end
                        OP_DUP: begin
                            sp <= sp + ONE;
                            pc <= pc + ONE;
                        end
                        OP_DROP: begin
                            sp  <= sp - ONE;
                            tos <= (sp >= TWO) ? ram_q : '0;
                            pc  <= pc + ONE;
                        end
                        default: begin
                            tos <= alu;
                            sp  <= sp - ONE;
                            pc  <= pc + ONE;
                        end
                    endcase
                end
                S_HALT, S_ERROR: state <= state;
                default: state <= S_FETCH;
            endcase
        end
    end
endmodule
